spi_reg_sequencer: RTL and testbench
====================================

Name: spi_reg_sequencer

Overview:
- SPI-clock-domain register-access controller that sequences the SPI slave datapath.
- Deserialises MOSI bits into a command byte followed by data bytes, and drives a register-file port with write/read strobes and an auto-incrementing address.
- Serialises read data onto MISO.
- Sits between the SPI pins/slave front-end and the SPI-domain control register file; runs only while the SPI clock toggles.

Parameters:
- ADDR_W, 7, register address width; fixed by command format (bit7 = R/W, bits6:0 = address).
- MAX_BURST, 16, maximum data bytes per frame; later bytes are ignored.
- AUTO_INC, 1, 1 = increment address after each data byte; 0 = hold address.

Ports:
- w_SPI_Clk  in  1  SPI sample clock, polarity/phase already resolved by the front-end.
- i_Rst_L  in  1  Reset, asynchronous, active-low.
- i_Frame_Start  in  1  High on the first w_SPI_Clk edge after CS_n falls (preload flag).
- i_SPI_MOSI  in  1  Serial data in, MSb first.
- o_SPI_MISO_Bit  out  1  Registered serial data out, before tri-state.
- o_Wr_En  out  1  Combinational write strobe; register file commits on the same edge.
- o_Rd_En  out  1  Combinational read strobe; i_Rd_Data must be valid in the same cycle.
- o_Addr  out  ADDR_W  Access address, valid when o_Wr_En or o_Rd_En is high.
- o_Wr_Data  out  8  Write byte = {shift[6:0], i_SPI_MOSI}.
- i_Rd_Data  in  8  Read data from register file (combinational).
- o_Byte_Count  out  clog2(MAX_BURST+1)  Data bytes completed in current frame, saturating.
- o_Overrun  out  1  Sticky: frame exceeded MAX_BURST; cleared on next frame start.

Behaviour:
- Reset values (async on i_Rst_L low): state IDLE, bit_cnt 0, shift 0, addr 0, tx_shift 0, o_SPI_MISO_Bit 0, o_Byte_Count 0, o_Overrun 0; strobes 0.
- "Edge k" = w_SPI_Clk rising edge with bit_cnt == k before the edge.
- i_Frame_Start forces k = 0 and state CMD from any state, including mid-byte. A partial previous byte is discarded with no strobe.
- bit_cnt: 3-bit counter, +1 per edge, wraps 7 -> 0; shift <= {shift[6:0], i_SPI_MOSI} each edge.
- States:
  - IDLE: bits ignored until i_Frame_Start.
  - CMD: at edge 7, cmd = {shift[6:0], MOSI}; addr <= cmd[6:0]; go to RD if cmd[7] = 1, else WR.
  - WR: at edge 7, o_Wr_En = 1 with o_Addr = addr and o_Wr_Data as above; then addr increments (AUTO_INC) and o_Byte_Count increments.
  - RD: each byte shifts tx_shift out. At edge 7, o_Rd_En = 1 prefetches the next address: addr+1 if AUTO_INC, else addr.
  - HOLD: entered when o_Byte_Count reaches MAX_BURST; o_Overrun <= 1; no strobes; MISO 0 until next frame start.
- Read prefetch:
  - CMD edge 7 with cmd[7] = 1: o_Rd_En = 1 with o_Addr = cmd[6:0] (combinational from shift/MOSI).
  - On any edge with o_Rd_En = 1: tx_shift <= i_Rd_Data; o_SPI_MISO_Bit <= i_Rd_Data[7].
  - At edge k = 0..6 of a read data byte: o_SPI_MISO_Bit <= tx_shift[6-k]. Each bit is presented one edge ahead of master sampling.
  - The prefetch on the final permitted byte (count = MAX_BURST-1) is suppressed.
- MISO is 0 during CMD, WR and HOLD.
- Address wrap: 7'h7F + 1 -> 7'h00, no flag.
- Strobes are never asserted in IDLE or on an edge where i_Frame_Start = 1.
- Clock stop after the last edge: strobes were combinational, so no stale pulse is committed at the next frame.

Decomposition:
- Package spi_reg_pkg:
  - state enum {IDLE, CMD, WR, RD, HOLD}
  - CMD_RW_BIT = 7
  - ADDR_W = 7
  - BYTE_W = 8
- One sub-module, spi_tx_shifter: load/shift MISO register with load enable, load data and bit index. Everything else stays in spi_reg_sequencer.

Test Plan:
- Write burst: frame start, MOSI 0x05,0xA1,0xB2 -> o_Wr_En pulses at bit 7 of bytes 2 and 3 with (addr 0x05, data 0xA1), (0x06, 0xB2); o_Byte_Count = 2; MISO stays 0.
- Read burst: MOSI 0x90 then two dummy bytes, regfile returns addr+0x40 -> o_Rd_En at addr 0x10, 0x11, 0x12; MISO streams 0x50 then 0x51 MSb first.
- Wrap: write command 0x7F with 2 data bytes -> writes to 0x7F then 0x00; with AUTO_INC = 0 both go to 0x7F.
- Overrun: MAX_BURST = 2, write frame with 3 data bytes -> 2 write strobes only; o_Overrun = 1 after byte 3; cleared to 0 on next i_Frame_Start.
- Mid-byte restart: i_Frame_Start asserted at bit 4 of a data byte -> no strobe for the partial byte; new command decoded correctly; o_Byte_Count = 0.
- Async reset: i_Rst_L low mid read frame -> all outputs 0 immediately; bits ignored until the next i_Frame_Start.

Source files
------------

// File: rtl/spi_reg_pkg.sv
// Shared types and command-format constants for the SPI register sequencer.
package spi_reg_pkg;
  localparam int ADDR_W     = 7;
  localparam int BYTE_W     = 8;
  localparam int CMD_RW_BIT = 7;

  typedef enum logic [2:0] {IDLE, CMD, WR, RD, HOLD} state_t;
endpackage

// File: rtl/spi_tx_shifter.sv
// MISO output register: loads a prefetched byte (MSb out at once) or walks
// the remaining seven bits by bit index; idles at 0.
module spi_tx_shifter
  import spi_reg_pkg::*;
(
  input  logic              w_SPI_Clk,
  input  logic              i_Rst_L,
  input  logic              load_en,
  input  logic [BYTE_W-1:0] load_data,
  input  logic              shift_en,
  input  logic [2:0]        bit_idx,
  output logic              miso
);
  // MSb leaves on load, so only the lower seven bits need holding.
  logic [BYTE_W-2:0] tx_shift;

  always_ff @(posedge w_SPI_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      tx_shift <= '0;
      miso     <= 1'b0;
    end else if (load_en) begin
      tx_shift <= load_data[BYTE_W-2:0];
      miso     <= load_data[BYTE_W-1];
    end else if (shift_en) begin
      miso <= tx_shift[3'd6 - bit_idx];
    end else begin
      miso <= 1'b0;
    end
  end
endmodule

// File: rtl/spi_reg_sequencer.sv
// SPI-domain register access sequencer: command byte, then write/read data
// bytes with auto-increment, read prefetch and burst limiting.
module spi_reg_sequencer #(
  parameter int ADDR_W    = spi_reg_pkg::ADDR_W,
  parameter int MAX_BURST = 16,
  parameter int AUTO_INC  = 1,
  localparam int CNT_W    = $clog2(MAX_BURST + 1)
) (
  input  logic              w_SPI_Clk,
  input  logic              i_Rst_L,
  input  logic              i_Frame_Start,
  input  logic              i_SPI_MOSI,
  output logic              o_SPI_MISO_Bit,
  output logic              o_Wr_En,
  output logic              o_Rd_En,
  output logic [ADDR_W-1:0] o_Addr,
  output logic [7:0]        o_Wr_Data,
  input  logic [7:0]        i_Rd_Data,
  output logic [CNT_W-1:0]  o_Byte_Count,
  output logic              o_Overrun
);
  import spi_reg_pkg::*;

  state_t            state;
  logic [2:0]        bit_cnt;
  logic [BYTE_W-2:0] shift;
  logic [ADDR_W-1:0] addr, addr_inc;
  logic [BYTE_W-1:0] cmd_byte;
  logic              at_last_bit, last_byte, tx_shift_en;

  // Frame start restarts the byte at bit 0, so it can never be a last bit.
  assign cmd_byte    = {shift, i_SPI_MOSI};
  assign at_last_bit = !i_Frame_Start && (bit_cnt == 3'd7);
  assign last_byte   = (o_Byte_Count == CNT_W'(MAX_BURST - 1));
  assign addr_inc    = (AUTO_INC != 0) ? addr + ADDR_W'(1) : addr;

  assign o_Wr_En   = at_last_bit && (state == WR);
  assign o_Rd_En   = at_last_bit && (((state == CMD) && cmd_byte[CMD_RW_BIT]) ||
                                     ((state == RD) && !last_byte));
  assign o_Addr    = (state == CMD) ? cmd_byte[ADDR_W-1:0] :
                     (state == RD)  ? addr_inc : addr;
  assign o_Wr_Data = cmd_byte;

  assign tx_shift_en = !i_Frame_Start && (state == RD) && (bit_cnt != 3'd7);

  always_ff @(posedge w_SPI_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state        <= IDLE;
      bit_cnt      <= 3'd0;
      shift        <= '0;
      addr         <= '0;
      o_Byte_Count <= '0;
      o_Overrun    <= 1'b0;
    end else begin
      shift <= cmd_byte[BYTE_W-2:0];
      if (i_Frame_Start) begin
        state        <= CMD;
        bit_cnt      <= 3'd1;
        o_Byte_Count <= '0;
        o_Overrun    <= 1'b0;
      end else begin
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          case (state)
            CMD: begin
              addr  <= cmd_byte[ADDR_W-1:0];
              state <= cmd_byte[CMD_RW_BIT] ? RD : WR;
            end
            WR, RD: begin
              // Read address only advances when a prefetch actually happened.
              if (state == WR || !last_byte) addr <= addr_inc;
              o_Byte_Count <= o_Byte_Count + CNT_W'(1);
              if (last_byte) state <= HOLD;
            end
            HOLD:    o_Overrun <= 1'b1;
            default: ;
          endcase
        end
      end
    end
  end

  spi_tx_shifter u_tx (
    .w_SPI_Clk (w_SPI_Clk),
    .i_Rst_L   (i_Rst_L),
    .load_en   (o_Rd_En),
    .load_data (i_Rd_Data),
    .shift_en  (tx_shift_en),
    .bit_idx   (bit_cnt),
    .miso      (o_SPI_MISO_Bit)
  );
endmodule

// File: tb/tb_spi_reg_sequencer.sv
// Scoreboard bench: per-edge expectations queued by stimulus, checked by monitors.
module tb_spi_reg_sequencer;
  logic clk = 1'b0, rst_n = 1'b1, fs = 1'b0, mosi = 1'b0;
  bit   sel = 1'b0;

  logic       miso0, wr0, rd0, ov0, miso1, wr1, rd1, ov1;
  logic [6:0] a0, a1;
  logic [7:0] wd0, wd1, rdd0, rdd1;
  logic [4:0] bc0;
  logic [1:0] bc1;

  assign rdd0 = {1'b0, a0} + 8'h40;
  assign rdd1 = {1'b0, a1} + 8'h40;

  spi_reg_sequencer dut0 (
    .w_SPI_Clk(clk), .i_Rst_L(rst_n), .i_Frame_Start(fs), .i_SPI_MOSI(mosi),
    .o_SPI_MISO_Bit(miso0), .o_Wr_En(wr0), .o_Rd_En(rd0), .o_Addr(a0),
    .o_Wr_Data(wd0), .i_Rd_Data(rdd0), .o_Byte_Count(bc0), .o_Overrun(ov0));

  spi_reg_sequencer #(.MAX_BURST(2), .AUTO_INC(0)) dut1 (
    .w_SPI_Clk(clk), .i_Rst_L(rst_n), .i_Frame_Start(fs), .i_SPI_MOSI(mosi),
    .o_SPI_MISO_Bit(miso1), .o_Wr_En(wr1), .o_Rd_En(rd1), .o_Addr(a1),
    .o_Wr_Data(wd1), .i_Rd_Data(rdd1), .o_Byte_Count(bc1), .o_Overrun(ov1));

  logic       m_wr, m_rd, m_miso;
  logic [6:0] m_addr;
  logic [7:0] m_wd;
  assign m_wr   = sel ? wr1   : wr0;
  assign m_rd   = sel ? rd1   : rd0;
  assign m_miso = sel ? miso1 : miso0;
  assign m_addr = sel ? a1    : a0;
  assign m_wd   = sel ? wd1   : wd0;

  typedef struct {
    logic       wr;
    logic       rd;
    logic [6:0] addr;
    logic [7:0] data;
    logic       miso;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e, none_e;
  int   total = 0, bad = 0;
  logic pend_miso = 1'b0;
  bit   pend_vld = 1'b0;
  event smp_ev;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Strobe monitor: sampled mid low phase, before the edge that commits.
  always @(smp_ev) begin
    if (exp_q.size() == 0) chk("queue_underflow", 32'd1, 32'd0);
    else begin
      mon_e = exp_q.pop_front();
      chk("wr_en", m_wr, mon_e.wr);
      chk("rd_en", m_rd, mon_e.rd);
      if (mon_e.wr || mon_e.rd) chk("addr", m_addr, mon_e.addr);
      if (mon_e.wr) chk("wr_data", m_wd, mon_e.data);
      pend_miso = mon_e.miso;
      pend_vld  = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (pend_vld) begin
      chk("miso", m_miso, pend_miso);
      pend_vld = 1'b0;
    end
  end

  task automatic do_bit(input logic b, input logic f, input exp_t e);
    mosi = b;
    fs   = f;
    exp_q.push_back(e);
    #2 -> smp_ev;
    #3 clk = 1'b1;
    #5 clk = 1'b0;
  endtask

  // mx bit (7-k) is the MISO value expected after edge k of this byte.
  task automatic send_byte(input logic [7:0] b, input bit f, input bit w, input bit r,
                           input logic [6:0] a, input logic [7:0] d, input logic [7:0] mx);
    exp_t e;
    for (int k = 0; k < 8; k++) begin
      e.wr   = w && (k == 7);
      e.rd   = r && (k == 7);
      e.addr = a;
      e.data = d;
      e.miso = mx[7-k];
      do_bit(b[7-k], f && (k == 0), e);
    end
    fs = 1'b0;
  endtask

  initial begin
    exp_t e;
    none_e = '{wr: 1'b0, rd: 1'b0, addr: 7'h0, data: 8'h0, miso: 1'b0};
    #1 rst_n = 1'b0;
    #2;
    chk("rst_wr", wr0, 0);     chk("rst_rd", rd0, 0);
    chk("rst_miso", miso0, 0); chk("rst_addr", a0, 0);
    chk("rst_wdata", wd0, 0);  chk("rst_cnt", bc0, 0);
    chk("rst_ovr", ov0, 0);    chk("rst_ovr1", ov1, 0);
    rst_n = 1'b1;
    #5;

    // write burst
    send_byte(8'h05, 1, 0, 0, 7'h00, 8'h00, 8'h00);
    send_byte(8'hA1, 0, 1, 0, 7'h05, 8'hA1, 8'h00);
    send_byte(8'hB2, 0, 1, 0, 7'h06, 8'hB2, 8'h00);
    chk("wr_count", bc0, 2);

    // read burst, regfile returns addr+0x40
    send_byte(8'h90, 1, 0, 1, 7'h10, 8'h00, 8'h00);
    send_byte(8'h00, 0, 0, 1, 7'h11, 8'h00, 8'hA0);
    send_byte(8'h00, 0, 0, 1, 7'h12, 8'h00, 8'hA2);
    chk("rd_count", bc0, 2);

    // address wrap, then held address
    send_byte(8'h7F, 1, 0, 0, 7'h00, 8'h00, 8'h00);
    send_byte(8'h11, 0, 1, 0, 7'h7F, 8'h11, 8'h00);
    send_byte(8'h22, 0, 1, 0, 7'h00, 8'h22, 8'h00);
    sel = 1'b1;
    send_byte(8'h7F, 1, 0, 0, 7'h00, 8'h00, 8'h00);
    send_byte(8'h11, 0, 1, 0, 7'h7F, 8'h11, 8'h00);
    send_byte(8'h22, 0, 1, 0, 7'h7F, 8'h22, 8'h00);
    chk("hold_no_ovr", ov1, 0);

    // overrun with MAX_BURST=2
    send_byte(8'h20, 1, 0, 0, 7'h00, 8'h00, 8'h00);
    send_byte(8'h01, 0, 1, 0, 7'h20, 8'h01, 8'h00);
    send_byte(8'h02, 0, 1, 0, 7'h20, 8'h02, 8'h00);
    chk("ovr_before", ov1, 0);
    send_byte(8'h03, 0, 0, 0, 7'h00, 8'h00, 8'h00);
    chk("ovr_after", ov1, 1);
    chk("ovr_count", bc1, 2);
    do_bit(1'b0, 1'b1, none_e);
    fs = 1'b0;
    chk("ovr_cleared", ov1, 0);
    chk("ovr_cnt_clr", bc1, 0);

    // read burst limit: last prefetch suppressed, then HOLD
    send_byte(8'h85, 1, 0, 1, 7'h05, 8'h00, 8'h00);
    send_byte(8'h00, 0, 0, 1, 7'h05, 8'h00, 8'h8A);
    send_byte(8'h00, 0, 0, 0, 7'h00, 8'h00, 8'h8A);
    send_byte(8'h00, 0, 0, 0, 7'h00, 8'h00, 8'h00);
    chk("rd_ovr", ov1, 1);
    chk("rd_ovr_cnt", bc1, 2);
    sel = 1'b0;

    // mid-byte restart
    send_byte(8'h40, 1, 0, 0, 7'h00, 8'h00, 8'h00);
    send_byte(8'hFF, 0, 1, 0, 7'h40, 8'hFF, 8'h00);
    for (int k = 0; k < 4; k++) do_bit(k[0] == 1'b0, 1'b0, none_e);
    send_byte(8'h30, 1, 0, 0, 7'h00, 8'h00, 8'h00);
    chk("restart_cnt0", bc0, 0);
    send_byte(8'h5A, 0, 1, 0, 7'h30, 8'h5A, 8'h00);
    chk("restart_cnt1", bc0, 1);

    // async reset mid read frame
    send_byte(8'h90, 1, 0, 1, 7'h10, 8'h00, 8'h00);
    e = none_e; e.miso = 1'b1; do_bit(1'b0, 1'b0, e);
    e.miso = 1'b0;             do_bit(1'b0, 1'b0, e);
    e.miso = 1'b1;             do_bit(1'b0, 1'b0, e);
    chk("pre_rst_miso", miso0, 1);
    mosi = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_miso", miso0, 0); chk("arst_wr", wr0, 0);
    chk("arst_rd", rd0, 0);     chk("arst_addr", a0, 0);
    chk("arst_cnt", bc0, 0);    chk("arst_wdata", wd0, 0);
    #2 rst_n = 1'b1;
    #2;
    send_byte(8'hFF, 0, 0, 0, 7'h00, 8'h00, 8'h00);
    send_byte(8'h01, 1, 0, 0, 7'h00, 8'h00, 8'h00);
    send_byte(8'h99, 0, 1, 0, 7'h01, 8'h99, 8'h00);

    #5;
    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
